// File: rtl/decoder_lut_pkg.sv
// Shared types and helpers for the programmable sum-of-minterms block.
package decoder_lut_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    function automatic int calcMinterms(input int nSel);
        return 1 << nSel;
    endfunction

endpackage

// File: rtl/decoder_nxm.sv
// Combinational N-to-2^N one-hot decoder with an active-high enable.
module decoder_nxm
    import decoder_lut_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                       i_en,
    input  logic [N-1:0]               i_sel,
    output logic [calcMinterms(N)-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_lut.sv
// Registered decoder driving a programmable minterm mask; the mask reloads MSB-first through a serial port.
module decoder_lut
    import decoder_lut_pkg::*;
#(
    parameter int                             N_SEL        = 4,
    parameter logic [calcMinterms(N_SEL)-1:0] DEFAULT_MASK = 16'h28AC
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             in_valid,
    input  logic [N_SEL-1:0]                 in_sel,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic                             out_f,
    output logic [calcMinterms(N_SEL)-1:0]   out_onehot,
    input  logic                             cfg_start,
    input  logic                             cfg_valid,
    input  logic                             cfg_bit,
    output logic                             cfg_busy,
    output logic                             cfg_done
);

    localparam int                M        = calcMinterms(N_SEL);
    localparam int                CNT_W    = $clog2(M) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(M - 1);

    state_t             r_state;
    logic [M-1:0]       r_mask;
    logic [M-1:0]       r_shadow;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_outValid;
    logic               r_outF;
    logic [M-1:0]       r_outOnehot;
    logic               r_cfgDone;

    logic               w_inReady;
    logic               w_accept;
    logic [M-1:0]       w_onehot;
    logic [M-1:0]       w_nextShadow;

    assign w_inReady    = (r_state == ST_IDLE);
    assign w_accept     = in_valid & w_inReady;
    assign w_nextShadow = {r_shadow[M-2:0], cfg_bit};

    decoder_nxm #(
        .N(N_SEL)
    ) u_decoder (
        .i_en    (en),
        .i_sel   (in_sel),
        .o_onehot(w_onehot)
    );

    // The mask only changes on the LOAD-ending cycle, when no accept is possible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mask      <= DEFAULT_MASK;
            r_shadow    <= '0;
            r_cnt       <= '0;
            r_outValid  <= 1'b0;
            r_outF      <= 1'b0;
            r_outOnehot <= '0;
            r_cfgDone   <= 1'b0;
        end else begin
            r_outValid <= w_accept;
            r_cfgDone  <= 1'b0;
            if (w_accept) begin
                r_outF      <= en & r_mask[in_sel];
                r_outOnehot <= w_onehot;
            end
            case (r_state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        r_state <= ST_LOAD;
                        r_cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (cfg_valid) begin
                        r_shadow <= w_nextShadow;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_mask    <= w_nextShadow;
                            r_cfgDone <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready   = w_inReady;
    assign cfg_busy   = (r_state == ST_LOAD);
    assign out_valid  = r_outValid;
    assign out_f      = r_outF;
    assign out_onehot = r_outOnehot;
    assign cfg_done   = r_cfgDone;

endmodule

// File: tb/tb_decoder_lut.sv
// Directed self-checking bench for decoder_lut at N_SEL=4 (default mask) and N_SEL=3 (parity mask).
module tb_decoder_lut;

    logic clk = 1'b0;
    logic rst;
    int   target;
    int   checks   = 0;
    int   failures = 0;

    logic       en, inValid, cfgStart, cfgValid, cfgBit;
    logic [3:0] inSel;

    logic        rdy4, ov4, f4, busy4, done4;
    logic [15:0] oh4;
    logic        rdy3, ov3, f3, busy3, done3;
    logic [7:0]  oh3;

    logic        obsReady, obsValid, obsF, obsBusy, obsDone;
    logic [15:0] obsOnehot;

    always #5 clk = ~clk;

    decoder_lut dut4 (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(inValid & (target == 0)), .in_sel(inSel), .in_ready(rdy4),
        .out_valid(ov4), .out_f(f4), .out_onehot(oh4),
        .cfg_start(cfgStart & (target == 0)), .cfg_valid(cfgValid & (target == 0)),
        .cfg_bit(cfgBit), .cfg_busy(busy4), .cfg_done(done4)
    );

    decoder_lut #(.N_SEL(3), .DEFAULT_MASK(8'h96)) dut3 (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(inValid & (target == 1)), .in_sel(inSel[2:0]), .in_ready(rdy3),
        .out_valid(ov3), .out_f(f3), .out_onehot(oh3),
        .cfg_start(cfgStart & (target == 1)), .cfg_valid(cfgValid & (target == 1)),
        .cfg_bit(cfgBit), .cfg_busy(busy3), .cfg_done(done3)
    );

    assign obsReady  = (target == 0) ? rdy4  : rdy3;
    assign obsValid  = (target == 0) ? ov4   : ov3;
    assign obsF      = (target == 0) ? f4    : f3;
    assign obsBusy   = (target == 0) ? busy4 : busy3;
    assign obsDone   = (target == 0) ? done4 : done3;
    assign obsOnehot = (target == 0) ? oh4   : {8'h00, oh3};

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One accept at a negedge; outputs are checked at the following negedge, then out_valid must drop.
    task automatic applyStimulus(input logic [3:0] sel, input logic enVal, input logic expF);
        logic [15:0] expOh;
        expOh = enVal ? (16'd1 << sel) : 16'd0;
        @(negedge clk);
        inValid = 1'b1;
        inSel   = sel;
        en      = enVal;
        @(negedge clk);
        inValid = 1'b0;
        checkOutput($sformatf("valid_sel%0d", sel), {31'd0, obsValid}, 32'd1);
        checkOutput($sformatf("f_sel%0d", sel), {31'd0, obsF}, {31'd0, expF});
        checkOutput($sformatf("onehot_sel%0d", sel), {16'd0, obsOnehot}, {16'd0, expOh});
        @(negedge clk);
        checkOutput($sformatf("valid_drop_sel%0d", sel), {31'd0, obsValid}, 32'd0);
        checkOutput($sformatf("hold_f_sel%0d", sel), {31'd0, obsF}, {31'd0, expF});
    endtask

    // Serial mask load MSB-first; a gap precedes every third bit. Optional accept of sel=2 with cfg_start.
    task automatic loadMask(input logic [15:0] value, input int nBits, input logic withAccept, input logic expF2);
        int doneCount;
        doneCount = 0;
        @(negedge clk);
        cfgStart = 1'b1;
        if (withAccept) begin
            inValid = 1'b1;
            inSel   = 4'd2;
            en      = 1'b1;
        end
        @(negedge clk);
        cfgStart = 1'b0;
        inValid  = 1'b0;
        if (withAccept) begin
            checkOutput("start_accept_valid", {31'd0, obsValid}, 32'd1);
            checkOutput("start_accept_oldmask_f", {31'd0, obsF}, {31'd0, expF2});
        end
        checkOutput("load_busy", {31'd0, obsBusy}, 32'd1);
        for (int i = nBits - 1; i >= 0; i--) begin
            if (i % 3 == 0) begin
                cfgValid = 1'b0;
                @(negedge clk);
                if (obsDone) doneCount++;
                checkOutput($sformatf("gap_ready_bit%0d", i), {31'd0, obsReady}, 32'd0);
            end
            cfgValid = 1'b1;
            cfgBit   = value[i];
            inValid  = 1'b1;
            inSel    = 4'd0;
            @(negedge clk);
            inValid  = 1'b0;
            if (obsDone) doneCount++;
            if (i > 0) begin
                checkOutput($sformatf("load_ready_bit%0d", i), {31'd0, obsReady}, 32'd0);
            end
        end
        cfgValid = 1'b0;
        checkOutput("post_load_busy", {31'd0, obsBusy}, 32'd0);
        checkOutput("post_load_ready", {31'd0, obsReady}, 32'd1);
        checkOutput("no_accept_during_load", {31'd0, obsValid}, 32'd0);
        @(negedge clk);
        if (obsDone) doneCount++;
        checkOutput("cfg_done_pulses", doneCount, 32'd1);
    endtask

    initial begin
        logic [15:0] maskA;
        logic [7:0]  mask3;
        target   = 0;
        rst      = 1'b1;
        en       = 1'b0;
        inValid  = 1'b0;
        inSel    = 4'd0;
        cfgStart = 1'b0;
        cfgValid = 1'b0;
        cfgBit   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 2; t++) begin
            target = t;
            #1;
            checkOutput($sformatf("rst_ready_%0d", t), {31'd0, obsReady}, 32'd1);
            checkOutput($sformatf("rst_valid_%0d", t), {31'd0, obsValid}, 32'd0);
            checkOutput($sformatf("rst_f_%0d", t), {31'd0, obsF}, 32'd0);
            checkOutput($sformatf("rst_onehot_%0d", t), {16'd0, obsOnehot}, 32'd0);
            checkOutput($sformatf("rst_busy_%0d", t), {31'd0, obsBusy}, 32'd0);
            checkOutput($sformatf("rst_done_%0d", t), {31'd0, obsDone}, 32'd0);
        end
        target = 0;

        $display("[TB] default mask sweep");
        for (int s = 0; s < 16; s++) begin
            applyStimulus(4'(s), 1'b1, (s == 2 || s == 3 || s == 5 || s == 7 || s == 11 || s == 13));
        end

        $display("[TB] decoder disabled");
        applyStimulus(4'd3, 1'b0, 1'b0);

        $display("[TB] load 16'h8001 with simultaneous accept");
        maskA = 16'h8001;
        loadMask(maskA, 16, 1'b1, 1'b1);
        applyStimulus(4'd0, 1'b1, 1'b1);
        applyStimulus(4'd15, 1'b1, 1'b1);
        applyStimulus(4'd7, 1'b1, 1'b0);
        applyStimulus(4'd2, 1'b1, 1'b0);

        $display("[TB] reset mid-load");
        @(negedge clk);
        cfgStart = 1'b1;
        @(negedge clk);
        cfgStart = 1'b0;
        cfgValid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cfgBit = 1'b1;
            @(negedge clk);
        end
        cfgValid = 1'b0;
        checkOutput("midload_busy", {31'd0, obsBusy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_midload_busy", {31'd0, obsBusy}, 32'd0);
        checkOutput("rst_midload_done", {31'd0, obsDone}, 32'd0);
        checkOutput("rst_midload_ready", {31'd0, obsReady}, 32'd1);
        @(negedge clk);
        checkOutput("rst_midload_done_late", {31'd0, obsDone}, 32'd0);
        applyStimulus(4'd5, 1'b1, 1'b1);
        applyStimulus(4'd0, 1'b1, 1'b0);

        $display("[TB] N_SEL=3 parity mask");
        target = 1;
        for (int s = 0; s < 8; s++) begin
            applyStimulus(4'(s), 1'b1, (s == 1 || s == 2 || s == 4 || s == 7));
        end
        mask3 = 8'hFF;
        loadMask({8'h00, mask3}, 8, 1'b0, 1'b0);
        for (int s = 0; s < 8; s++) begin
            applyStimulus(4'(s), 1'b1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
